// File: rtl/axil_ram.sv
// axil_ram: AXI4-Lite slave RAM with independent AW/W holding registers and registered B/R channels.
// Define AXIL_RAM_ERR_RESP_EN to suppress out-of-range writes and answer them with SLVERR.
module axil_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 65536,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int LSB    = $clog2(STRB_WIDTH);
  logic [DATA_WIDTH-1:0] mem [MEM_BYTES/STRB_WIDTH];
  logic                  aw_full, w_full, commit, ar_hs, aw_err, ar_err, unused;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [MEM_AW-LSB-1:0] aw_idx, ar_idx;
  // Readies are held low during reset; they never look at the valid inputs.
  assign s_axil_awready = rst_n && !aw_full;
  assign s_axil_wready  = rst_n && !w_full;
  assign s_axil_arready = rst_n && (!s_axil_rvalid || s_axil_rready);
  assign commit = aw_full && w_full && (!s_axil_bvalid || s_axil_bready);
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign aw_idx = aw_addr[MEM_AW-1:LSB];
  assign ar_idx = s_axil_araddr[MEM_AW-1:LSB];
`ifdef AXIL_RAM_ERR_RESP_EN
  assign aw_err = (aw_addr >> MEM_AW) != '0;
  assign ar_err = (s_axil_araddr >> MEM_AW) != '0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  assign unused = ^{s_axil_awprot, s_axil_arprot, aw_addr, s_axil_araddr};
  // Storage and payload registers carry no reset; only the control state does.
  always_ff @(posedge clk) begin
    if (s_axil_awvalid && s_axil_awready) aw_addr <= s_axil_awaddr;
    if (s_axil_wvalid && s_axil_wready) begin
      w_data <= s_axil_wdata;
      w_strb <= s_axil_wstrb;
    end
    if (commit && !aw_err)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= 2'b00;
      s_axil_rdata  <= '0;
    end else begin
      aw_full <= commit ? 1'b0 : (aw_full || s_axil_awvalid);
      w_full  <= commit ? 1'b0 : (w_full || s_axil_wvalid);
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= aw_err ? 2'b10 : 2'b00;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= ar_err ? '0 : mem[ar_idx];
        s_axil_rresp  <= ar_err ? 2'b10 : 2'b00;
      end else if (s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_ram.sv
// tb_axil_ram: vector table, hand-built handshake corner cases and a randomized byte-level memory model for axil_ram.
module tb_axil_ram;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0;
  logic [2:0]  s_axil_awprot = '0, s_axil_arprot = '0;
  logic        s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  int checks = 0, failures = 0;

  axil_ram dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  logic [7:0] ref_mem [int];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n;
    bit a_done, w_done, ah, wh;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
    a_done = 0; w_done = 0; n = 0;
    while (!(a_done && w_done) && n < 50) begin
      ah = s_axil_awvalid && s_axil_awready;
      wh = s_axil_wvalid && s_axil_wready;
      step();
      if (ah) begin a_done = 1; s_axil_awvalid = 0; end
      if (wh) begin w_done = 1; s_axil_wvalid = 0; end
      n++;
    end
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("wr_accept", {a_done, w_done}, 2'b11);
    n = 0;
    while (!s_axil_bvalid && n < 50) begin step(); n++; end
    chk("b_latency", n, 1);
    resp = s_axil_bresp;
    s_axil_bready = 1;
    step();
    s_axil_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit hs;
    s_axil_araddr = a; s_axil_arvalid = 1; s_axil_rready = 0;
    hs = 0; n = 0;
    while (!hs && n < 50) begin hs = s_axil_arready; step(); n++; end
    s_axil_arvalid = 0;
    chk("ar_accept", hs, 1);
    chk("r_latency", s_axil_rvalid, 1);
    d = s_axil_rdata; resp = s_axil_rresp;
    s_axil_rready = 1;
    step();
    s_axil_rready = 0;
  endtask

  initial begin
    vec_t vt[5];
    logic [31:0] d, exp, a, prev;
    logic [1:0] r;
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_exp[3];
    int got, issued, cyc;
    bit ar_hs, r_hs, stall;
    vt[0] = '{32'h20,   32'h01020304, 4'hF,    32'h20,   32'h01020304};
    vt[1] = '{32'h20,   32'hFFFFFFFF, 4'b1000, 32'h21,   32'hFF020304};
    vt[2] = '{32'h20,   32'h0000AA00, 4'b0010, 32'h22,   32'hFF02AA04};
    vt[3] = '{32'hFFFC, 32'h89ABCDEF, 4'hF,    32'hFFFF, 32'h89ABCDEF};
    vt[4] = '{32'h0,    32'h12345678, 4'hF,    32'h0,    32'h12345678};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_wready", s_axil_wready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_bvalid", s_axil_bvalid, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_resp", {s_axil_bresp, s_axil_rresp}, 0);
    #3 rst_n = 1;
    #1;
    chk("rel_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    step();

    // basic write/read and partial strobe with unaligned read address
    do_write(32'h10, 32'hDEADBEEF, 4'hF, r);
    chk("basic_bresp", r, 0);
    do_read(32'h10, d, r);
    chk("basic_rdata", d, 32'hDEADBEEF);
    chk("basic_rresp", r, 0);
    do_write(32'h10, 32'h11223344, 4'b0101, r);
    do_read(32'h13, d, r);
    chk("strb_rdata", d, 32'hDE22BE44);

    for (int i = 0; i < 5; i++) begin
      do_write(vt[i].waddr, vt[i].wdata, vt[i].strb, r);
      chk("vec_bresp", r, 0);
      do_read(vt[i].raddr, d, r);
      chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
      chk("vec_rresp", r, 0);
    end

    // W three cycles ahead of AW, B held off, second write stalls behind it
    s_axil_bready = 0;
    s_axil_wdata = 32'h55667788; s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    chk("w_early_ready", s_axil_wready, 1);
    step();
    s_axil_wvalid = 0;
    chk("w_held_wready", s_axil_wready, 0);
    step();
    chk("no_b_before_aw", s_axil_bvalid, 0);
    step();
    chk("no_b_before_aw", s_axil_bvalid, 0);
    s_axil_awaddr = 32'h40; s_axil_awvalid = 1;
    chk("aw_late_ready", s_axil_awready, 1);
    step();
    s_axil_awvalid = 0;
    chk("b_not_yet", s_axil_bvalid, 0);
    step();
    chk("b_after_commit", {s_axil_bvalid, s_axil_bresp}, 3'b100);
    chk("aw_reopen", {s_axil_awready, s_axil_wready}, 2'b11);
    s_axil_awaddr = 32'h44; s_axil_wdata = 32'h00000099; s_axil_awvalid = 1; s_axil_wvalid = 1;
    step();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bstall_readies", {s_axil_awready, s_axil_wready}, 2'b00);
      chk("bstall_b_held", {s_axil_bvalid, s_axil_bresp}, 3'b100);
      step();
    end
    s_axil_bready = 1;
    step();
    chk("b2_after_handshake", s_axil_bvalid, 1);
    chk("readies_after_commit", {s_axil_awready, s_axil_wready}, 2'b11);
    step();
    chk("b_drained", s_axil_bvalid, 0);
    s_axil_bready = 0;
    do_read(32'h40, d, r);
    chk("w_early_data", d, 32'h55667788);
    do_read(32'h44, d, r);
    chk("stalled_data", d, 32'h00000099);

    // back-to-back reads with rready toggling
    do_write(32'h4, 32'hA0A0A0A4, 4'hF, r);
    do_write(32'h8, 32'hB0B0B0B8, 4'hF, r);
    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
    b2b_exp[0] = 32'h12345678; b2b_exp[1] = 32'hA0A0A0A4; b2b_exp[2] = 32'hB0B0B0B8;
    got = 0; issued = 0; cyc = 0;
    s_axil_araddr = b2b_addr[0]; s_axil_arvalid = 1;
    while (got < 3 && cyc < 40) begin
      s_axil_rready = (cyc % 2) == 0;
      #0;
      chk("arready_rule", s_axil_arready, !(s_axil_rvalid && !s_axil_rready));
      ar_hs = s_axil_arvalid && s_axil_arready;
      r_hs = s_axil_rvalid && s_axil_rready;
      stall = s_axil_rvalid && !s_axil_rready;
      prev = s_axil_rdata;
      if (r_hs) begin
        chk($sformatf("b2b_beat%0d", got), s_axil_rdata, b2b_exp[got]);
        got++;
      end
      step();
      if (stall) chk("r_stable", {s_axil_rvalid, s_axil_rdata}, {1'b1, prev});
      if (ar_hs) begin
        issued++;
        if (issued < 3) s_axil_araddr = b2b_addr[issued];
        else s_axil_arvalid = 0;
      end
      cyc++;
    end
    s_axil_arvalid = 0; s_axil_rready = 0;
    chk("b2b_beats", got, 3);
    chk("b2b_issued", issued, 3);
    chk("b2b_no_extra", s_axil_rvalid, 0);

    // out-of-range write
    do_write(32'h10000, 32'hCAFEF00D, 4'hF, r);
`ifdef AXIL_RAM_ERR_RESP_EN
    chk("oor_bresp", r, 2'b10);
    do_read(32'h0, d, r);
    chk("oor_no_alias", {d, r}, {32'h12345678, 2'b00});
    do_read(32'h10000, d, r);
    chk("oor_read", {d, r}, {32'h0, 2'b10});
`else
    chk("oor_bresp", r, 2'b00);
    do_read(32'h0, d, r);
    chk("oor_alias", {d, r}, {32'hCAFEF00D, 2'b00});
`endif

    // randomized traffic against a byte-addressed reference memory
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      a = 32'h1000 + 32'(w * 4);
      do_write(a, d, 4'hF, r);
      for (int b = 0; b < 4; b++) ref_mem[int'(a) + b] = d[8*b +: 8];
    end
    for (int k = 0; k < 40; k++) begin
      a = 32'h1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        logic [3:0] s;
        d = $urandom;
        s = 4'($urandom);
        do_write(a, d, s, r);
        chk("rnd_bresp", r, 0);
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[int'(a & ~32'h3) + b] = d[8*b +: 8];
      end else begin
        do_read(a, d, r);
        for (int b = 0; b < 4; b++) exp[8*b +: 8] = ref_mem[int'(a & ~32'h3) + b];
        chk("rnd_rdata", {d, r}, {exp, 2'b00});
      end
    end

    // reset mid-transaction with R pending and AW held
    do_write(32'h80, 32'h00000077, 4'hF, r);
    s_axil_awaddr = 32'h84; s_axil_awvalid = 1;
    s_axil_araddr = 32'h80; s_axil_arvalid = 1; s_axil_rready = 0; s_axil_bready = 1;
    step();
    s_axil_awvalid = 0; s_axil_arvalid = 0;
    chk("pre_rst_state", {s_axil_rvalid, s_axil_awready}, 2'b10);
    #3 rst_n = 0;
    #1;
    chk("rst_drop_rvalid", s_axil_rvalid, 0);
    chk("rst_drop_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1;
    step();
    chk("post_rst_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_b", s_axil_bvalid, 0);
      step();
    end
    s_axil_bready = 0;
    do_read(32'h80, d, r);
    chk("post_rst_data", d, 32'h00000077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
